// File: rtl/rx_frame_ctrl_if.sv
// Consumer-side bundle of rx_frame_ctrl: receiver strobe/frame, FIFO read port, error status.
interface rx_frame_ctrl_if #(
  parameter int unsigned DEPTH = 4
) ();
  logic                     rx_done;
  logic [8:0]               rx_frame;
  logic                     m_ready;
  logic                     clr_err;
  logic                     m_valid;
  logic [7:0]               m_data;
  logic                     m_perr;
  logic [$clog2(DEPTH):0]   level;
  logic                     overrun;
  logic [7:0]               perr_cnt;

  // Driver side: receiver front end plus consumer.
  modport master (
    output rx_done, rx_frame, m_ready, clr_err,
    input  m_valid, m_data, m_perr, level, overrun, perr_cnt
  );

  // Frame controller side.
  modport slave (
    input  rx_done, rx_frame, m_ready, clr_err,
    output m_valid, m_data, m_perr, level, overrun, perr_cnt
  );
endinterface

// File: rtl/rx_frame_ctrl.sv
// Receive frame controller: edge-detects rx_done, checks parity and queues {perr, data} in a FIFO.
module rx_frame_ctrl #(
  parameter bit          PARITY_EN  = 1'b1,
  parameter bit          PARITY_ODD = 1'b0,
  parameter int unsigned DEPTH      = 4
) (
  input  logic           Rx_clk,
  input  logic           rst_n,
  rx_frame_ctrl_if.slave bus
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned LW = PW + 1;

  typedef enum logic [1:0] {StIdle, StCheck, StWrite} state_e;

  state_e          state_q, state_d;
  logic            done_q;
  logic            armed_q, armed_d;
  logic [8:0]      frame_q, frame_d;
  logic            perr_q, perr_d;
  logic [8:0]      mem_q [DEPTH];
  logic [8:0]      mem_d [DEPTH];
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]   level_q, level_d;
  logic            valid_q, valid_d;
  logic            overrun_q, overrun_d;
  logic [7:0]      perr_cnt_q, perr_cnt_d;

  logic capture;
  logic latch_en, check_en, write_en, late_edge;
  logic full, pop, push, drop;

  // Armed only once rx_done has been seen low, so a strobe held across reset is not captured.
  assign capture = bus.rx_done & ~done_q & armed_q;
  assign armed_d = armed_q | ~bus.rx_done;

  // State register.
  always_ff @(posedge Rx_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (capture) state_d = StCheck;
      StCheck: state_d = StWrite;
      StWrite: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // FSM output decode.
  always_comb begin
    latch_en  = 1'b0;
    check_en  = 1'b0;
    write_en  = 1'b0;
    late_edge = 1'b0;
    unique case (state_q)
      StIdle:  latch_en = capture;
      StCheck: begin
        check_en  = 1'b1;
        late_edge = capture;
      end
      StWrite: begin
        write_en  = 1'b1;
        late_edge = capture;
      end
      default: ;
    endcase
  end

  assign full = (level_q == LW'(DEPTH));
  assign pop  = valid_q & bus.m_ready;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
  assign push = write_en & (~full | pop);
  assign drop = write_en & full & ~pop;

  // Datapath and FIFO next-state.
  always_comb begin
    frame_d    = latch_en ? bus.rx_frame : frame_q;
    perr_d     = perr_q;
    if (check_en) begin
      perr_d = PARITY_EN & ((^frame_q) ^ PARITY_ODD);
    end

    mem_d = mem_q;
    if (push) begin
      mem_d[wr_ptr_q] = {perr_q, frame_q[8:1]};
    end
    wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;

    level_d = level_q;
    if (push && !pop) begin
      level_d = level_q + LW'(1);
    end else if (pop && !push) begin
      level_d = level_q - LW'(1);
    end
    valid_d = (level_d != '0);

    overrun_d  = overrun_q | drop | late_edge;
    perr_cnt_d = perr_cnt_q;
    if (write_en && perr_q && (perr_cnt_q != 8'hFF)) begin
      perr_cnt_d = perr_cnt_q + 8'd1;
    end
    if (bus.clr_err) begin
      overrun_d  = 1'b0;
      perr_cnt_d = 8'd0;
    end
  end

  // Datapath, FIFO and status registers.
  always_ff @(posedge Rx_clk or negedge rst_n) begin
    if (!rst_n) begin
      done_q     <= 1'b0;
      armed_q    <= 1'b0;
      frame_q    <= '0;
      perr_q     <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      valid_q    <= 1'b0;
      overrun_q  <= 1'b0;
      perr_cnt_q <= 8'd0;
    end else begin
      done_q     <= bus.rx_done;
      armed_q    <= armed_d;
      frame_q    <= frame_d;
      perr_q     <= perr_d;
      mem_q      <= mem_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      valid_q    <= valid_d;
      overrun_q  <= overrun_d;
      perr_cnt_q <= perr_cnt_d;
    end
  end

  // Head entry is presented straight from storage.
  assign bus.m_data   = mem_q[rd_ptr_q][7:0];
  assign bus.m_perr   = mem_q[rd_ptr_q][8];
  assign bus.m_valid  = valid_q;
  assign bus.level    = level_q;
  assign bus.overrun  = overrun_q;
  assign bus.perr_cnt = perr_cnt_q;

endmodule
